// File: rtl/sr_control_mc.sv
// Multi-cycle control FSM for schoolRISCV: fetch/decode/exec/mem/wb
// sequencing with memory handshakes, data-memory timeout trap and instret.
module sr_control_mc #(
   parameter int ALU_W   = 4,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       cmdOp,
   input  logic [2:0]       cmdF3,
   input  logic [6:0]       cmdF7,
   input  logic             aluZero,
   input  logic             aluLt,
   input  logic             imemAck,
   input  logic             dmemAck,
   output logic             irWe,
   output logic             imemReq,
   output logic             dmemReq,
   output logic             dmemWe,
   output logic             pcWe,
   output logic             pcSrc,
   output logic             regWrite,
   output logic [1:0]       aluSrc,
   output logic [1:0]       wdSrc,
   output logic [ALU_W-1:0] aluControl,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
   localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
   localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(2);
   localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(3);
   localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(4);
   localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(5);
   localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(6);
   localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(7);
   localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(8);

   localparam logic [1:0] SRC_B_RD2   = 2'd0;
   localparam logic [1:0] SRC_B_IMM_I = 2'd1;
   localparam logic [1:0] SRC_B_IMM_S = 2'd2;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [2:0] K_ILL = 3'd0;
   localparam logic [2:0] K_ALU = 3'd1;
   localparam logic [2:0] K_LUI = 3'd2;
   localparam logic [2:0] K_LW  = 3'd3;
   localparam logic [2:0] K_SW  = 3'd4;
   localparam logic [2:0] K_BR  = 3'd5;

   localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [2:0]       state, nextState;
   logic [2:0]       kind;
   logic [ALU_W-1:0] aluOp;
   logic [1:0]       srcB;
   logic             brTaken;
   logic [WCW-1:0]   waitCnt;
   logic             timeout;
   logic [CNT_W-1:0] instretQ;

   // Instruction classification from the latched IR fields
   always_comb begin
      kind    = K_ILL;
      aluOp   = ALU_ADD;
      srcB    = SRC_B_RD2;
      brTaken = 1'b0;
      unique case (cmdOp)
         OP_R: begin
            kind = K_ALU;
            unique case ({cmdF7, cmdF3})
               {7'h00, 3'b000}: aluOp = ALU_ADD;
               {7'h20, 3'b000}: aluOp = ALU_SUB;
               {7'h00, 3'b111}: aluOp = ALU_AND;
               {7'h00, 3'b110}: aluOp = ALU_OR;
               {7'h00, 3'b100}: aluOp = ALU_XOR;
               {7'h00, 3'b001}: aluOp = ALU_SLL;
               {7'h00, 3'b101}: aluOp = ALU_SRL;
               {7'h00, 3'b011}: aluOp = ALU_SLTU;
               default:         kind  = K_ILL;
            endcase
         end
         OP_I: begin
            kind = K_ALU;
            srcB = SRC_B_IMM_I;
            unique case (cmdF3)
               3'b000: aluOp = ALU_ADD;
               3'b111: aluOp = ALU_AND;
               3'b110: aluOp = ALU_OR;
               3'b100: aluOp = ALU_XOR;
               3'b001: begin
                  aluOp = ALU_SLL;
                  if (cmdF7 != 7'h00) kind = K_ILL;
               end
               3'b101: begin
                  aluOp = ALU_SRL;
                  if (cmdF7 != 7'h00) kind = K_ILL;
               end
               default: kind = K_ILL;
            endcase
         end
         OP_LUI: kind = K_LUI;
         OP_LOAD: begin
            srcB = SRC_B_IMM_I;
            kind = (cmdF3 == 3'b010) ? K_LW : K_ILL;
         end
         OP_STORE: begin
            srcB = SRC_B_IMM_S;
            kind = (cmdF3 == 3'b010) ? K_SW : K_ILL;
         end
         OP_BR: begin
            kind = K_BR;
            unique case (cmdF3)
               3'b000: begin aluOp = ALU_SUB;  brTaken = aluZero;  end
               3'b001: begin aluOp = ALU_SUB;  brTaken = !aluZero; end
               3'b100: begin aluOp = ALU_SLT;  brTaken = aluLt;    end
               3'b101: begin aluOp = ALU_SLT;  brTaken = !aluLt;   end
               3'b110: begin aluOp = ALU_SLTU; brTaken = aluLt;    end
               3'b111: begin aluOp = ALU_SLTU; brTaken = !aluLt;   end
               default: kind = K_ILL;
            endcase
         end
         default: kind = K_ILL;
      endcase
   end

   // An ack in the last allowed cycle still wins over the timeout
   assign timeout = (TIMEOUT != 0) &&
                    (waitCnt == WCW'(TIMEOUT - 1)) && !dmemAck;

   always_comb begin
      nextState  = state;
      irWe       = 1'b0;
      imemReq    = 1'b0;
      dmemReq    = 1'b0;
      dmemWe     = 1'b0;
      pcWe       = 1'b0;
      pcSrc      = 1'b0;
      regWrite   = 1'b0;
      aluSrc     = SRC_B_RD2;
      wdSrc      = 2'd0;
      aluControl = ALU_ADD;
      trap       = 1'b0;
      unique case (state)
         S_FETCH: begin
            imemReq = 1'b1;
            if (imemAck) begin
               irWe      = 1'b1;
               nextState = S_DECODE;
            end
         end
         S_DECODE: nextState = (kind == K_ILL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            aluControl = aluOp;
            aluSrc     = srcB;
            unique case (kind)
               K_ALU, K_LUI: nextState = S_WB;
               K_LW, K_SW:   nextState = S_MEM;
               K_BR: begin
                  pcWe      = 1'b1;
                  pcSrc     = brTaken;
                  nextState = S_FETCH;
               end
               default: nextState = S_TRAP;
            endcase
         end
         S_MEM: begin
            dmemReq = 1'b1;
            dmemWe  = (kind == K_SW);
            if (dmemAck) begin
               pcWe      = (kind == K_SW);
               nextState = (kind == K_SW) ? S_FETCH : S_WB;
            end else if (timeout) begin
               nextState = S_TRAP;
            end
         end
         S_WB: begin
            regWrite  = 1'b1;
            pcWe      = 1'b1;
            wdSrc     = (kind == K_LUI) ? 2'd1 :
                        (kind == K_LW)  ? 2'd2 : 2'd0;
            nextState = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: nextState = S_FETCH;
      endcase
      if (!rst_n) begin
         irWe       = 1'b0;
         imemReq    = 1'b0;
         dmemReq    = 1'b0;
         dmemWe     = 1'b0;
         pcWe       = 1'b0;
         pcSrc      = 1'b0;
         regWrite   = 1'b0;
         aluSrc     = SRC_B_RD2;
         wdSrc      = 2'd0;
         aluControl = ALU_ADD;
         trap       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         waitCnt  <= '0;
         instretQ <= '0;
      end else begin
         state    <= nextState;
         waitCnt  <= (state == S_MEM) ? waitCnt + WCW'(1) : '0;
         if (pcWe) instretQ <= instretQ + CNT_W'(1);
      end
   end

   assign instret = rst_n ? instretQ : '0;

endmodule

// File: tb/tb_sr_control_mc.sv
// Bench for sr_control_mc: per-instruction cycle model driven by a
// mnemonic table, checked against the DUT every cycle.
module tb_sr_control_mc;

   localparam int TO = 15;

   localparam logic [3:0] A_ADD  = 4'd0;
   localparam logic [3:0] A_SUB  = 4'd1;
   localparam logic [3:0] A_AND  = 4'd2;
   localparam logic [3:0] A_OR   = 4'd3;
   localparam logic [3:0] A_XOR  = 4'd4;
   localparam logic [3:0] A_SLL  = 4'd5;
   localparam logic [3:0] A_SRL  = 4'd6;
   localparam logic [3:0] A_SLT  = 4'd7;
   localparam logic [3:0] A_SLTU = 4'd8;

   localparam logic [1:0] B_RD2 = 2'd0;
   localparam logic [1:0] B_IMI = 2'd1;
   localparam logic [1:0] B_IMS = 2'd2;

   localparam int C_ILL = 0;
   localparam int C_ALU = 1;
   localparam int C_LUI = 2;
   localparam int C_LW  = 3;
   localparam int C_SW  = 4;
   localparam int C_BR  = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  cmdOp;
   logic [2:0]  cmdF3;
   logic [6:0]  cmdF7;
   logic        aluZero, aluLt, imemAck, dmemAck;
   logic        irWe, imemReq, dmemReq, dmemWe, pcWe, pcSrc;
   logic        regWrite, trap;
   logic [1:0]  aluSrc, wdSrc;
   logic [3:0]  aluControl;
   logic [31:0] instret;

   always #5 clk = ~clk;

   sr_control_mc #(.ALU_W(4), .TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
      .aluZero(aluZero), .aluLt(aluLt),
      .imemAck(imemAck), .dmemAck(dmemAck),
      .irWe(irWe), .imemReq(imemReq), .dmemReq(dmemReq),
      .dmemWe(dmemWe), .pcWe(pcWe), .pcSrc(pcSrc),
      .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc),
      .aluControl(aluControl), .trap(trap), .instret(instret)
   );

   typedef struct packed {
      logic       irWe, imemReq, dmemReq, dmemWe, pcWe, pcSrc;
      logic       regWrite;
      logic [1:0] aluSrc, wdSrc;
      logic [3:0] aluCtl;
      logic       trap;
   } outs_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int         cls;
      logic [3:0] alu;
      logic [1:0] src;
      int         cond;
   } ent_t;

   ent_t        tbl [28];
   outs_t       expO;
   outs_t       act;
   bit          expV = 1'b0;
   logic [31:0] expInstret = '0;
   int          vectors = 0;
   int          errors = 0;

   assign act = {irWe, imemReq, dmemReq, dmemWe, pcWe, pcSrc,
                 regWrite, aluSrc, wdSrc, aluControl, trap};

   always @(negedge clk) begin
      if (expV) begin
         vectors++;
         if (act !== expO) begin
            errors++;
            $display("FAIL outs t=%0t got %h want %h",
                     $time, act, expO);
         end
         vectors++;
         if (instret !== expInstret) begin
            errors++;
            $display("FAIL instret t=%0t got %0d want %0d",
                     $time, instret, expInstret);
         end
      end
   end

   function automatic outs_t idle();
      outs_t o;
      o = '0;
      o.aluCtl = A_ADD;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic cyc(input outs_t e);
      expO = e;
      expV = 1'b1;
      @(posedge clk);
      if (e.pcWe) expInstret++;
      #1;
   endtask

   task automatic put(input int i, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input int cls, input logic [3:0] alu,
                      input logic [1:0] src, input int cond);
      tbl[i] = '{op, f3, f7, cls, alu, src, cond};
   endtask

   task automatic doReset(input int n);
      rst_n   = 1'b0;
      imemAck = 1'b0;
      dmemAck = 1'b0;
      expInstret = '0;
      repeat (n) cyc(idle());
      rst_n = 1'b1;
      #1;
   endtask

   task automatic trapCycles(input int n);
      outs_t o;
      o = idle();
      o.trap = 1'b1;
      imemAck = 1'b1;
      dmemAck = 1'b1;
      repeat (n) cyc(o);
      imemAck = 1'b0;
      dmemAck = 1'b0;
   endtask

   // dw: waits before dmemAck (-1 = never); stop: abort after that many waits
   task automatic runInstr(input int idx, input int iw, input int dw,
                           input bit z, input bit l, input int stop);
      ent_t  e;
      outs_t o;
      bit    tk;
      int    waits;
      e = tbl[idx];
      cmdOp = e.op;
      cmdF3 = e.f3;
      cmdF7 = e.f7;
      aluZero = z;
      aluLt = l;
      o = idle();
      o.imemReq = 1'b1;
      imemAck = 1'b0;
      repeat (iw) cyc(o);
      imemAck = 1'b1;
      o.irWe = 1'b1;
      cyc(o);
      imemAck = 1'b0;
      cyc(idle());
      if (e.cls == C_ILL) return;
      o = idle();
      o.aluCtl = e.alu;
      o.aluSrc = e.src;
      if (e.cls == C_BR) begin
         case (e.cond)
            1: tk = z;
            2: tk = !z;
            3: tk = l;
            default: tk = !l;
         endcase
         o.pcWe = 1'b1;
         o.pcSrc = tk;
         cyc(o);
         return;
      end
      cyc(o);
      if (e.cls == C_LW || e.cls == C_SW) begin
         o = idle();
         o.dmemReq = 1'b1;
         o.dmemWe = (e.cls == C_SW);
         dmemAck = 1'b0;
         waits = (dw < 0) ? TO : dw;
         if (stop > 0) waits = stop;
         repeat (waits) cyc(o);
         if (dw < 0 || stop > 0) return;
         dmemAck = 1'b1;
         o.pcWe = (e.cls == C_SW);
         cyc(o);
         dmemAck = 1'b0;
         if (e.cls == C_SW) return;
      end
      o = idle();
      o.regWrite = 1'b1;
      o.pcWe = 1'b1;
      o.wdSrc = (e.cls == C_LUI) ? 2'd1 :
                (e.cls == C_LW)  ? 2'd2 : 2'd0;
      cyc(o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      put(0,  7'b0110011, 3'b000, 7'h00, C_ALU, A_ADD,  B_RD2, 0);
      put(1,  7'b0110011, 3'b000, 7'h20, C_ALU, A_SUB,  B_RD2, 0);
      put(2,  7'b0110011, 3'b111, 7'h00, C_ALU, A_AND,  B_RD2, 0);
      put(3,  7'b0110011, 3'b110, 7'h00, C_ALU, A_OR,   B_RD2, 0);
      put(4,  7'b0110011, 3'b100, 7'h00, C_ALU, A_XOR,  B_RD2, 0);
      put(5,  7'b0110011, 3'b001, 7'h00, C_ALU, A_SLL,  B_RD2, 0);
      put(6,  7'b0110011, 3'b101, 7'h00, C_ALU, A_SRL,  B_RD2, 0);
      put(7,  7'b0110011, 3'b011, 7'h00, C_ALU, A_SLTU, B_RD2, 0);
      put(8,  7'b0010011, 3'b000, 7'h55, C_ALU, A_ADD,  B_IMI, 0);
      put(9,  7'b0010011, 3'b111, 7'h7f, C_ALU, A_AND,  B_IMI, 0);
      put(10, 7'b0010011, 3'b110, 7'h01, C_ALU, A_OR,   B_IMI, 0);
      put(11, 7'b0010011, 3'b100, 7'h40, C_ALU, A_XOR,  B_IMI, 0);
      put(12, 7'b0010011, 3'b001, 7'h00, C_ALU, A_SLL,  B_IMI, 0);
      put(13, 7'b0010011, 3'b101, 7'h00, C_ALU, A_SRL,  B_IMI, 0);
      put(14, 7'b0110111, 3'b011, 7'h12, C_LUI, A_ADD,  B_RD2, 0);
      put(15, 7'b0000011, 3'b010, 7'h03, C_LW,  A_ADD,  B_IMI, 0);
      put(16, 7'b0100011, 3'b010, 7'h04, C_SW,  A_ADD,  B_IMS, 0);
      put(17, 7'b1100011, 3'b000, 7'h00, C_BR,  A_SUB,  B_RD2, 1);
      put(18, 7'b1100011, 3'b001, 7'h00, C_BR,  A_SUB,  B_RD2, 2);
      put(19, 7'b1100011, 3'b100, 7'h00, C_BR,  A_SLT,  B_RD2, 3);
      put(20, 7'b1100011, 3'b101, 7'h00, C_BR,  A_SLT,  B_RD2, 4);
      put(21, 7'b1100011, 3'b110, 7'h00, C_BR,  A_SLTU, B_RD2, 3);
      put(22, 7'b1100011, 3'b111, 7'h00, C_BR,  A_SLTU, B_RD2, 4);
      put(23, 7'b0000000, 3'b000, 7'h00, C_ILL, A_ADD,  B_RD2, 0);
      put(24, 7'b0010011, 3'b010, 7'h00, C_ILL, A_ADD,  B_RD2, 0);
      put(25, 7'b0110011, 3'b001, 7'h20, C_ILL, A_ADD,  B_RD2, 0);
      put(26, 7'b0010011, 3'b101, 7'h20, C_ILL, A_ADD,  B_RD2, 0);
      put(27, 7'b1100011, 3'b010, 7'h00, C_ILL, A_ADD,  B_RD2, 0);

      rst_n = 1'b0;
      cmdOp = '0;
      cmdF3 = '0;
      cmdF7 = '0;
      aluZero = 1'b0;
      aluLt = 1'b0;
      imemAck = 1'b0;
      dmemAck = 1'b0;
      @(posedge clk);
      #1;

      doReset(2);
      chk("rstInstret", instret, 0);
      chk("rstFetchReq", {31'd0, imemReq}, 1);
      runInstr(8, 0, 0, 1'b0, 1'b0, 0);
      chk("addiInstret", instret, 1);

      runInstr(18, 0, 0, 1'b0, 1'b0, 0);
      runInstr(17, 0, 0, 1'b0, 1'b0, 0);
      chk("branchInstret", instret, 3);
      runInstr(21, 0, 0, 1'b0, 1'b1, 0);
      runInstr(20, 0, 0, 1'b0, 1'b1, 0);
      chk("bltuBgeInstret", instret, 5);

      runInstr(15, 0, 3, 1'b0, 1'b0, 0);
      chk("lwInstret", instret, 6);
      runInstr(16, 2, 0, 1'b0, 1'b0, 0);
      chk("swInstret", instret, 7);

      for (int i = 0; i <= 22; i++) begin
         for (int p = 0; p < 4; p++) begin
            runInstr(i, (i + p) % 3, p % 2, p[0], p[1], 0);
         end
      end

      runInstr(15, 0, TO - 1, 1'b0, 1'b0, 0);
      runInstr(16, 1, TO - 1, 1'b0, 1'b0, 0);

      runInstr(16, 0, -1, 1'b0, 1'b0, 0);
      trapCycles(5);
      chk("trapSticky", {31'd0, trap}, 1);
      chk("trapNoPcWe", {31'd0, pcWe}, 0);
      doReset(1);
      chk("trapCleared", {31'd0, trap}, 0);

      for (int i = 23; i <= 27; i++) begin
         runInstr(i, i % 2, 0, 1'b0, 1'b0, 0);
         trapCycles(3);
         doReset(1);
      end

      runInstr(15, 1, 0, 1'b0, 1'b0, 3);
      doReset(1);
      chk("midRstDmemReq", {31'd0, dmemReq}, 0);
      chk("midRstInstret", instret, 0);
      runInstr(8, 0, 0, 1'b0, 1'b0, 0);
      chk("postRstInstret", instret, 1);

      expV = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
